univ_shift_reg_seq: RTL and testbench
=====================================

// Module: univ_shift_reg_seq
// PURPOSE
//  Parametrised universal shift register with a multi-cycle command engine.
//  A command (op + amount) is accepted on a start pulse. The block then shifts or rotates
//  one bit position per cycle until the amount is used up, and signals completion with done.
//  Serial fill/drain ports make it usable as a SPI-style serialiser or a barrel-shift substitute.
// PARAMETERS
//  N   8               register width, N >= 2
//  AW  $clog2(N+1)     width of amt (derived localparam; not overridable)
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   command strobe; sampled only while busy==0
//  op       in   3   shift_op_t command code
//  amt      in   AW  bit positions to shift; values > N are clamped to N
//  d        in   N   parallel load data (LOAD)
//  ser_in   in   1   serial fill bit for SHL/SHR; sampled live at every shift edge
//  q        out  N   register contents
//  sout     out  1   bit expelled by the most recent shift/rotate edge
//  busy     out  1   multi-cycle command in progress
//  done     out  1   one-cycle completion pulse; q is final while done==1
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. rst has priority over start.
//    Reset values: q=0, sout=0, busy=0, done=0, FSM=IDLE. Reset mid-command aborts it; no done is emitted.
//  - Op codes:
//    000 NOP: no change.
//    001 LOAD: q<=d.
//    010 SHL: {q[N-2:0],ser_in}.
//    011 SHR: {ser_in,q[N-1:1]}.
//    100 ROL.
//    101 ROR.
//    110 ASR: fill with q[N-1].
//    111 CLR: q<=0.
//  - FSM states: IDLE, SHIFT.
//  - IDLE with start=1, call that edge E0:
//    NOP/LOAD/CLR, or a shift op with amt==0: action happens at E0; done=1 for the following cycle;
//    busy stays 0; FSM stays IDLE.
//    Shift op with amt>0: latch op and min(amt,N) into cnt; busy=1 after E0; FSM -> SHIFT; q unchanged at E0.
//  - SHIFT: each edge Ek performs one step (k=1..cnt) and updates sout.
//    At the last edge: busy->0, done->1 for one cycle, FSM -> IDLE.
//    busy is high for exactly cnt cycles; total latency is cnt+1 edges from E0.
//  - start while busy==1 is ignored: not queued, no error. op/amt/d are only sampled at E0.
//  - Back-to-back commands: start may be high in the same cycle done is high (FSM already IDLE);
//    it is accepted normally.
//  - sout: SHL/ROL = old q[N-1]; SHR/ROR/ASR = old q[0]. Holds between shifts.
//    Unchanged by LOAD/CLR/NOP.
//  - amt==N with ROL/ROR returns q to its original value after N cycles. ASR by N yields all sign bits.
// STRUCTURE
//  - Package shift_pkg:
//    typedef enum logic[2:0] shift_op_t {NOP,LOAD,SHL,SHR,ROL,ROR,ASR,CLR};
//    typedef enum logic state_t {IDLE,SHIFT};
//    function is_multicycle(shift_op_t).
//  - Sub-module shift_step #(N): purely combinational single-position shifter.
//    Inputs: op, q, ser_in. Outputs: next q, out bit.
//    Instantiated once; the top holds the FSM, count-down counter and registers.
// TESTING (N=8)
//  1. Hold rst=1 with start=1, op=LOAD, d=FF for 1 edge -> q=00, busy=0, done=0, sout=0.
//  2. start, LOAD, d=A5 -> after E0: q=A5, done=1 for one cycle, busy never 1.
//  3. q=A5, start SHL amt=3 ser_in=1 -> busy=1 for 3 cycles; q: 4B, 97, 2F.
//     done with q=2F, sout=1.
//  4. q=90, start ASR amt=2 -> q: C8, E4; done with q=E4, sout=0.
//     Then ROR amt=8 on q=3C -> q=3C after 8 busy cycles.
//     A start pulse (LOAD 00) during busy is ignored.
//  5. SHR amt=0 on q=5A -> done next cycle, q=5A, busy=0.
//     amt=15 (AW=4) with ROL -> clamped to 8 busy cycles.
//  6. q=FF, SHL amt=5 ser_in=0; assert rst after 2 shifts -> q=00, busy=0, no done pulse.
//     A new LOAD accepted on the next cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - command codes, FSM states and helpers for the universal shift register
package shift_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        ASR  = 3'b110,
        CLR  = 3'b111
    } shift_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift/rotate ops walk one bit per cycle; the others complete at the accept edge.
    function automatic logic is_multicycle(input shift_op_t op);
        return (op == SHL) || (op == SHR) || (op == ROL) || (op == ROR) || (op == ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shifter
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  shift_op_t      op,
    input  logic [N-1:0]   q,
    input  logic           ser_in,
    output logic [N-1:0]   q_next,
    output logic           out_bit
);

    // One position of movement; out_bit is the bit pushed off the end.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (op)
            SHL: begin
                q_next  = {q[N-2:0], ser_in};
                out_bit = q[N-1];
            end
            SHR: begin
                q_next  = {ser_in, q[N-1:1]};
                out_bit = q[0];
            end
            ROL: begin
                q_next  = {q[N-2:0], q[N-1]};
                out_bit = q[N-1];
            end
            ROR: begin
                q_next  = {q[0], q[N-1:1]};
                out_bit = q[0];
            end
            ASR: begin
                q_next  = {q[N-1], q[N-1:1]};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// rtl/univ_shift_reg_seq.sv - universal shift register with multi-cycle command engine
module univ_shift_reg_seq
    import shift_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  d,
    input  logic          ser_in,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    state_t          state;
    state_t          state_next;
    shift_op_t       cmd_op;
    shift_op_t       op_r;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   amt_clamped;
    logic            accept;
    logic            launch;
    logic            last_step;
    logic [N-1:0]    step_q;
    logic            step_out;

    assign cmd_op      = shift_op_t'(op);
    assign amt_clamped = (amt > AW'(N)) ? AW'(N) : amt;
    assign accept      = (state == IDLE) && start;
    assign launch      = accept && is_multicycle(cmd_op) && (amt != '0);
    assign last_step   = (state == SHIFT) && (cnt == AW'(1));

    // The latched op drives the shifter; it is only consumed while in SHIFT.
    shift_step #(.N(N)) u_step (
        .op      (op_r),
        .q       (q),
        .ser_in  (ser_in),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter SHIFT on a non-trivial shift command, leave after the final step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)    state_next = SHIFT;
            SHIFT:   if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Datapath: register contents, expelled bit, step counter and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            sout <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            op_r <= NOP;
        end else begin
            done <= (accept && !launch) || last_step;
            if (state == SHIFT) begin
                q    <= step_q;
                sout <= step_out;
                cnt  <= cnt - AW'(1);
            end else if (accept) begin
                if (launch) begin
                    op_r <= cmd_op;
                    cnt  <= amt_clamped;
                end else if (cmd_op == LOAD) begin
                    q <= d;
                end else if (cmd_op == CLR) begin
                    q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// tb/tb_univ_shift_reg_seq.sv - self-checking bench for univ_shift_reg_seq
module tb_univ_shift_reg_seq;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          ser_in;
    logic [N-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    int m_q;
    int m_sout;
    int m_done;
    int m_rem;
    int m_op;

    univ_shift_reg_seq #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .d      (d),
        .ser_in (ser_in),
        .q      (q),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One step of a shift/rotate op on the model register, using plain integer arithmetic.
    task automatic model_step(input int opc, input int ser);
        int v;
        v = m_q;
        case (opc)
            2: begin m_sout = (v >> 7) & 1; m_q = ((v * 2) + ser) % 256; end
            3: begin m_sout = v % 2;        m_q = (v / 2) + ser * 128; end
            4: begin m_sout = (v >> 7) & 1; m_q = ((v * 2) % 256) + (v / 128); end
            5: begin m_sout = v % 2;        m_q = (v / 2) + (v % 2) * 128; end
            6: begin m_sout = v % 2;        m_q = (v / 2) + (v / 128) * 128; end
            default: ;
        endcase
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_q = 0; m_sout = 0; m_done = 0; m_rem = 0; m_op = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                model_step(m_op, int'(ser_in));
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end else if (start) begin
                if (op >= 3'd2 && op <= 3'd6 && amt != 0) begin
                    m_op  = int'(op);
                    m_rem = (int'(amt) > N) ? N : int'(amt);
                end else begin
                    if (op == 3'd1) m_q = int'(d);
                    if (op == 3'd7) m_q = 0;
                    m_done = 1;
                end
            end
        end
        #1;
        check_eq("q",    int'(q),    m_q);
        check_eq("sout", int'(sout), m_sout);
        check_eq("busy", int'(busy), (m_rem > 0) ? 1 : 0);
        check_eq("done", int'(done), m_done);
    endtask

    // Issue one command and run it to completion; optionally pulse a LOAD 00 mid-command.
    task automatic run_cmd(input int opc, input int a, input int dv, input int inj,
                           output int busy_cycles);
        int n;
        start = 1'b1; op = 3'(opc); amt = AW'(a); d = 8'(dv);
        tick();
        start = 1'b0;
        n = 0;
        while (m_rem > 0 && n < 20) begin
            if (n == inj) begin
                start = 1'b1; op = 3'd1; d = 8'h00;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check_eq("cmd_bound", (n < 20) ? 1 : 0, 1);
        busy_cycles = n;
    endtask

    initial begin
        int bc;
        rst = 1'b0; start = 1'b0; op = 3'd0; amt = '0; d = '0; ser_in = 1'b0;
        m_q = 0; m_sout = 0; m_done = 0; m_rem = 0; m_op = 0;
        @(negedge clk);

        // 1. reset wins over a simultaneous LOAD
        rst = 1'b1; start = 1'b1; op = 3'd1; d = 8'hFF;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rst_q", int'(q), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_sout", int'(sout), 0);

        // 2. single-cycle LOAD
        run_cmd(1, 0, 8'hA5, -1, bc);
        check_eq("load_busy_cycles", bc, 0);
        check_eq("load_q", int'(q), 8'hA5);
        check_eq("load_done", int'(done), 1);

        // 3. SHL by 3 with ser_in=1 (started in the done cycle: back-to-back)
        ser_in = 1'b1;
        start = 1'b1; op = 3'd2; amt = 4'd3;
        tick();
        start = 1'b0;
        check_eq("shl_e0_q", int'(q), 8'hA5);
        tick(); check_eq("shl_e1", int'(q), 8'h4B);
        tick(); check_eq("shl_e2", int'(q), 8'h97);
        tick(); check_eq("shl_e3", int'(q), 8'h2F);
        check_eq("shl_done", int'(done), 1);
        check_eq("shl_sout", int'(sout), 1);
        ser_in = 1'b0;

        // 4. ASR by 2, then ROR by N with an ignored start during busy
        run_cmd(1, 0, 8'h90, -1, bc);
        run_cmd(6, 2, 0, -1, bc);
        check_eq("asr_cycles", bc, 2);
        check_eq("asr_q", int'(q), 8'hE4);
        check_eq("asr_sout", int'(sout), 0);
        run_cmd(1, 0, 8'h3C, -1, bc);
        run_cmd(5, 8, 0, 3, bc);
        check_eq("ror_cycles", bc, 8);
        check_eq("ror_q", int'(q), 8'h3C);

        // 5. zero amount and clamped amount
        run_cmd(1, 0, 8'h5A, -1, bc);
        run_cmd(3, 0, 0, -1, bc);
        check_eq("shr0_cycles", bc, 0);
        check_eq("shr0_q", int'(q), 8'h5A);
        check_eq("shr0_done", int'(done), 1);
        run_cmd(4, 15, 0, -1, bc);
        check_eq("rol_clamp_cycles", bc, 8);
        check_eq("rol_clamp_q", int'(q), 8'h5A);

        // 6. reset aborts a running SHL; a new LOAD follows
        run_cmd(1, 0, 8'hFF, -1, bc);
        start = 1'b1; op = 3'd2; amt = 4'd5; ser_in = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_q", int'(q), 0);
        check_eq("abort_busy", int'(busy), 0);
        tick();
        check_eq("abort_no_done", int'(done), 0);
        run_cmd(1, 0, 8'hC3, -1, bc);
        check_eq("post_abort_load", int'(q), 8'hC3);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 2) == 0);
            op     = 3'($urandom_range(0, 7));
            amt    = AW'($urandom_range(0, 15));
            d      = 8'($urandom);
            ser_in = 1'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
